// File: rtl/bcd_conv_sched.sv
// ---------------------------------------------------------------------------
// bcd_conv_sched
//   Shared binary-to-BCD converter serving two requesters with round-robin
//   arbitration. One conversion runs at a time: IDLE picks a requester and
//   captures its operand, SHIFT runs W double-dabble iterations (one per
//   cycle), DONE presents the result and pulses the matching done.
//
// Ports
//   clk             clock, all state on posedge
//   rst             synchronous, active-high reset
//   req0/req1       conversion requests, held until the matching gnt
//   bin0/bin1       W-bit operands, stable while the request is high
//   gnt0/gnt1       one-cycle pulse in the first SHIFT cycle of a conversion
//   done0/done1     one-cycle pulse while bcd/overflow carry that result
//   bcd             {hundreds, tens, units} of the last completed conversion
//   overflow        captured operand > OVF_LIMIT, last completed conversion
//   busy            FSM not in IDLE
// ---------------------------------------------------------------------------

// One BCD digit's pre-shift correction: add 3 when the digit is >= 5 so the
// following left shift carries correctly into the next decade.
module bcd_digit_adj (
  input  logic [3:0] din,
  output logic [3:0] dout
);
  assign dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule

module bcd_conv_sched #(
  parameter int W         = 8,
  parameter int OVF_LIMIT = 99
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic [W-1:0] bin0,
  input  logic         req1,
  input  logic [W-1:0] bin1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         done0,
  output logic         done1,
  output logic [11:0]  bcd,
  output logic         overflow,
  output logic         busy
);

  localparam int          NDIG      = 3;
  localparam int          CW        = $clog2(W + 1);
  localparam logic [31:0] OVF_LIM_U = 32'(OVF_LIMIT);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  // Result presented on the output ports; held between done pulses.
  typedef struct packed {
    logic [11:0] bcd;
    logic        ovf;
  } res_t;

  state_t                    state_q, state_d;
  logic [NDIG-1:0][3:0]      acc_q, acc_adj;
  logic [W-1:0]              op_q;
  logic [CW-1:0]             cnt_q;
  logic                      last_q;   // requester served most recently
  logic                      sel_q;    // requester of the conversion in flight
  logic                      ovf_q;    // overflow of the captured operand
  res_t                      res_q;

  logic                      load, step, finish, last_iter;
  logic                      pick;
  logic [W-1:0]              cap;
  logic                      cap_ovf;
  logic [4*NDIG+W-1:0]       sh;

  // -------------------------------------------------------------------------
  // Arbitration: a lone request wins outright; on a tie the requester that
  // was not served last goes next.
  // -------------------------------------------------------------------------
  always_comb begin
    pick = req1;
    if (req0 && req1) pick = ~last_q;
  end

  assign cap     = pick ? bin1 : bin0;
  assign cap_ovf = (32'(cap) > OVF_LIM_U);

  // -------------------------------------------------------------------------
  // Double-dabble step: correct each digit, then shift {bcd, operand} left
  // so the operand MSB enters the units LSB.
  // -------------------------------------------------------------------------
  for (genvar d = 0; d < NDIG; d++) begin : g_dig
    bcd_digit_adj u_adj (
      .din  (acc_q[d]),
      .dout (acc_adj[d])
    );
  end

  assign sh        = {acc_adj, op_q} << 1;
  assign last_iter = (cnt_q == CW'(W - 1));

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d = SHIFT;
          load    = 1'b1;
        end
      end
      SHIFT: begin
        step = 1'b1;
        if (last_iter) begin
          state_d = DONE;
          finish  = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath and output pulses. gnt is registered off the accepting edge so
  // it lines up with the first SHIFT cycle; the result and done are
  // registered off the last iteration so they line up with DONE.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      op_q   <= '0;
      cnt_q  <= '0;
      last_q <= 1'b1;
      sel_q  <= 1'b0;
      ovf_q  <= 1'b0;
      res_q  <= '0;
      gnt0   <= 1'b0;
      gnt1   <= 1'b0;
      done0  <= 1'b0;
      done1  <= 1'b0;
    end else begin
      gnt0  <= load & ~pick;
      gnt1  <= load &  pick;
      done0 <= finish & ~sel_q;
      done1 <= finish &  sel_q;
      if (load) begin
        acc_q  <= '0;
        op_q   <= cap;
        cnt_q  <= '0;
        sel_q  <= pick;
        last_q <= pick;
        ovf_q  <= cap_ovf;
      end else if (step) begin
        acc_q <= sh[4*NDIG+W-1:W];
        op_q  <= sh[W-1:0];
        cnt_q <= cnt_q + 1'b1;
        if (finish) begin
          res_q.bcd <= sh[4*NDIG+W-1:W];
          res_q.ovf <= ovf_q;
        end
      end
    end
  end

  assign bcd      = res_q.bcd;
  assign overflow = res_q.ovf;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_bcd_conv_sched.sv
// ---------------------------------------------------------------------------
// tb_bcd_conv_sched
//   Scoreboard bench: each driven conversion pushes its expected
//   {requester, bcd, overflow}; a monitor pops and compares on done, and also
//   checks done latency, pulse exclusivity and result hold between dones.
// ---------------------------------------------------------------------------
module tb_bcd_conv_sched;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0 = 1'b0, req1 = 1'b0;
  logic [W-1:0] bin0 = '0, bin1 = '0;
  logic         gnt0, gnt1, done0, done1, overflow, busy;
  logic [11:0]  bcd;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int gnt_cyc = 0;
  logic [11:0] hold_bcd = '0;
  logic        hold_ovf = 1'b0;

  typedef struct packed {
    logic        who;
    logic [11:0] bcd;
    logic        ovf;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bcd_conv_sched #(.W(W), .OVF_LIMIT(99)) dut (
    .clk      (clk),
    .rst      (rst),
    .req0     (req0),
    .bin0     (bin0),
    .req1     (req1),
    .bin1     (bin1),
    .gnt0     (gnt0),
    .gnt1     (gnt1),
    .done0    (done0),
    .done1    (done1),
    .bcd      (bcd),
    .overflow (overflow),
    .busy     (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic logic [11:0] bcd_of(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic exp_t mk(input int who, input int v);
    exp_t e;
    e.who = 1'(who);
    e.bcd = bcd_of(v);
    e.ovf = (v > 99);
    return e;
  endfunction

  // Monitor: scoreboard pop on done, latency, exclusivity, hold.
  always @(negedge clk) begin : mon
    exp_t e;
    if (gnt0 | gnt1) begin
      chk("gnt_excl", 32'(gnt0 & gnt1), 32'(0));
      gnt_cyc <= cyc;
    end
    if (rst) begin
      hold_bcd <= '0;
      hold_ovf <= 1'b0;
    end else if (done0 | done1) begin
      chk("done_excl", 32'(done0 & done1), 32'(0));
      if (exp_q.size() == 0) begin
        chk("done_unexp", 32'({done1, done0}), 32'(0));
      end else begin
        e = exp_q.pop_front();
        chk("done_who", 32'({done1, done0}), e.who ? 32'(2) : 32'(1));
        chk("bcd", 32'(bcd), 32'(e.bcd));
        chk("ovf", 32'(overflow), 32'(e.ovf));
        chk("done_lat", 32'(cyc - gnt_cyc), 32'(W));
        hold_bcd <= e.bcd;
        hold_ovf <= e.ovf;
      end
    end else begin
      chk("hold_bcd", 32'(bcd), 32'(hold_bcd));
      chk("hold_ovf", 32'(overflow), 32'(hold_ovf));
    end
  end

  task automatic wait_gnt(output int who, output int idle);
    bit ok;
    ok = 0; idle = 0; who = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (gnt0 | gnt1) begin
        who = gnt1 ? 1 : 0;
        ok  = 1;
        break;
      end
      if (!busy) idle++;
    end
    chk("gnt_timeout", 32'(ok), 32'(1));
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1;
        break;
      end
    end
    chk("idle_timeout", 32'(ok), 32'(1));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Single conversion from one requester; optionally disturb the operand
  // the cycle after the grant.
  task automatic conv(input int who, input int v, input bit scramble);
    int g, idl, t0;
    @(negedge clk);
    exp_q.push_back(mk(who, v));
    if (who != 0) begin req1 = 1'b1; bin1 = 8'(v); end
    else          begin req0 = 1'b1; bin0 = 8'(v); end
    t0 = cyc;
    wait_gnt(g, idl);
    chk("gnt_who", 32'(g), 32'(who));
    chk("gnt_lat", 32'(cyc - t0), 32'(1));
    req0 = 1'b0; req1 = 1'b0;
    if (scramble) begin
      @(negedge clk);
      if (who != 0) bin1 = ~bin1;
      else          bin0 = ~bin0;
    end
    wait_idle();
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int g, idl, prev, t0;
    prev = 0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy",  32'(busy), 32'(0));
    chk("rst_bcd",   32'(bcd), 32'(0));
    chk("rst_ovf",   32'(overflow), 32'(0));
    chk("rst_gnt",   32'({gnt1, gnt0}), 32'(0));
    chk("rst_done",  32'({done1, done0}), 32'(0));
    rst = 1'b0;

    // Full-scale operand
    conv(0, 255, 1'b0);

    // Simultaneous requests held: alternate 0,1,0,1 every W+2 cycles
    do_reset();
    @(negedge clk);
    exp_q.push_back(mk(0, 42));
    exp_q.push_back(mk(1, 99));
    exp_q.push_back(mk(0, 42));
    exp_q.push_back(mk(1, 99));
    req0 = 1'b1; bin0 = 8'd42;
    req1 = 1'b1; bin1 = 8'd99;
    for (int k = 0; k < 4; k++) begin
      wait_gnt(g, idl);
      chk("rr_who", 32'(g), 32'(k % 2));
      if (k > 0) begin
        chk("rr_period", 32'(cyc - prev), 32'(W + 2));
        chk("rr_idle", 32'(idl), 32'(1));
      end
      prev = cyc;
      if (k == 3) begin
        req0 = 1'b0; req1 = 1'b0;
      end
    end
    wait_idle();

    // Reset in the 4th SHIFT cycle aborts with no done
    do_reset();
    @(negedge clk);
    req0 = 1'b1; bin0 = 8'd200;
    wait_gnt(g, idl);
    chk("abort_gnt", 32'(g), 32'(0));
    req0 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_bcd",  32'(bcd), 32'(0));
    chk("abort_ovf",  32'(overflow), 32'(0));
    chk("abort_pulse", 32'({gnt1, gnt0, done1, done0}), 32'(0));
    rst = 1'b0;
    repeat (12) @(negedge clk);
    conv(1, 100, 1'b0);

    // Boundary operands and operand stability
    conv(0, 0, 1'b0);
    conv(0, 99, 1'b0);
    conv(0, 100, 1'b0);
    conv(0, 37, 1'b1);
    conv(1, 200, 1'b1);

    // Request held through reset deassertion
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    exp_q.push_back(mk(0, 77));
    req0 = 1'b1; bin0 = 8'd77;
    @(negedge clk);
    rst = 1'b0;
    t0 = cyc;
    @(negedge clk);
    chk("rst_hold_gnt", 32'({gnt1, gnt0}), 32'(1));
    chk("rst_hold_lat", 32'(cyc - t0), 32'(1));
    req0 = 1'b0;
    wait_idle();

    // Random operands from random requesters
    for (int i = 0; i < 8; i++) begin
      int who, v;
      who = int'($urandom_range(0, 1));
      v   = int'($urandom_range(0, 255));
      conv(who, v, 1'b0);
    end

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(exp_q.size()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
